// File: rtl/rom_arbiter.sv
// Round-robin arbiter and 3-cycle sequencer sharing one synchronous genrom port
// between the fetch path (requester 0) and a secondary agent (requester 1).
module rom_arbiter #(
  parameter int MEM_ADDR  = 6,
  parameter int MEM_EXTRA = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req0,
  input  logic                           req1,
  input  logic [MEM_ADDR:0]              addr0,
  input  logic [MEM_ADDR:0]              addr1,
  input  logic [MEM_EXTRA-1:0]           extra0,
  input  logic [MEM_EXTRA-1:0]           extra1,
  output logic                           ack0,
  output logic                           ack1,
  output logic                           rvalid0,
  output logic                           rvalid1,
  output logic [(2**MEM_EXTRA)*8-1:0]    rdata,
  output logic                           rerror,
  output logic                           busy,
  input  logic                           cfg_we,
  input  logic [1:0]                     cfg_sel,
  input  logic [MEM_ADDR:0]              cfg_data,
  output logic [MEM_ADDR:0]              mem_addr,
  output logic [MEM_EXTRA-1:0]           mem_extra,
  output logic [MEM_ADDR:0]              mem_lower,
  output logic [MEM_ADDR:0]              mem_upper,
  input  logic [(2**MEM_EXTRA)*8-1:0]    mem_data,
  input  logic                           mem_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               last;       // requester granted most recently; also owns the in-flight access
  logic               gnt_valid;
  logic               gnt_sel;
  logic [MEM_ADDR:0]  lower0;
  logic [MEM_ADDR:0]  upper0;
  logic [MEM_ADDR:0]  lower1;
  logic [MEM_ADDR:0]  upper1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    gnt_valid = 1'b0;
    gnt_sel   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt_valid = 1'b1;
          gnt_sel   = (req0 && req1) ? ~last : req1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: the upper bounds reset to all ones, not zero, so a fresh window
  // spans the whole ROM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lower0 <= '0;
      upper0 <= '1;
      lower1 <= '0;
      upper1 <= '1;
    end else if (cfg_we) begin
      case (cfg_sel)
        2'd0: lower0 <= cfg_data;
        2'd1: upper0 <= cfg_data;
        2'd2: lower1 <= cfg_data;
        2'd3: upper1 <= cfg_data;
        default: ;
      endcase
    end
  end

  // Bounds are sampled from the pre-edge registers, so a coincident config
  // write only affects the following grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last      <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata     <= '0;
      rerror    <= 1'b0;
      mem_addr  <= '0;
      mem_extra <= '0;
      mem_lower <= '0;
      mem_upper <= '1;
    end else begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (gnt_valid) begin
        last      <= gnt_sel;
        ack0      <= ~gnt_sel;
        ack1      <= gnt_sel;
        mem_addr  <= gnt_sel ? addr1  : addr0;
        mem_extra <= gnt_sel ? extra1 : extra0;
        mem_lower <= gnt_sel ? lower1 : lower0;
        mem_upper <= gnt_sel ? upper1 : upper0;
      end
      if (state == WAIT) begin
        rdata   <= mem_data;
        rerror  <= mem_error;
        rvalid0 <= ~last;
        rvalid1 <= last;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: transaction-level timing model plus a
// synchronous ROM stand-in, driven by directed scenarios and random traffic.
module tb_rom_arbiter;

  localparam int MEM_ADDR  = 6;
  localparam int MEM_EXTRA = 4;
  localparam int AW        = MEM_ADDR + 1;
  localparam int DW        = (2 ** MEM_EXTRA) * 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req0, req1;
  logic [AW-1:0]        addr0, addr1;
  logic [MEM_EXTRA-1:0] extra0, extra1;
  logic                 ack0, ack1, rvalid0, rvalid1, rerror, busy;
  logic [DW-1:0]        rdata;
  logic                 cfg_we;
  logic [1:0]           cfg_sel;
  logic [AW-1:0]        cfg_data;
  logic [AW-1:0]        mem_addr, mem_lower, mem_upper;
  logic [MEM_EXTRA-1:0] mem_extra;
  logic [DW-1:0]        mem_data = '0;
  logic                 mem_error = 1'b0;

  rom_arbiter #(.MEM_ADDR(MEM_ADDR), .MEM_EXTRA(MEM_EXTRA)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .extra0(extra0), .extra1(extra1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .rerror(rerror), .busy(busy),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_lower(mem_lower), .mem_upper(mem_upper),
    .mem_data(mem_data), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  // ROM contents: byte k of a read is (addr + k), valid for k <= extra.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a, input logic [MEM_EXTRA-1:0] x);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < 2 ** MEM_EXTRA; k++)
      if (k <= int'(x)) w[k*8 +: 8] = 8'(int'(a) + k);
    return w;
  endfunction

  function automatic logic rom_err(input logic [AW-1:0] a, input logic [AW-1:0] lo, input logic [AW-1:0] up);
    return (a < lo) || (a > up);
  endfunction

  always @(posedge clk) begin
    mem_data  <= rom_word(mem_addr, mem_extra);
    mem_error <= rom_err(mem_addr, mem_lower, mem_upper);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: grants allowed once the previous access has had its
  // 3-cycle slot; response lands 2 edges after the grant.
  int                   cyc;
  int                   free_at;
  int                   rv_due;
  int                   rv_who;
  int                   m_last;
  logic [AW-1:0]        lo [2];
  logic [AW-1:0]        up [2];
  logic [DW-1:0]        pend_data, exp_rdata;
  logic                 pend_err, exp_rerr;
  logic [AW-1:0]        exp_maddr, exp_mlo, exp_mup;
  logic [MEM_EXTRA-1:0] exp_mextra;
  logic                 m_ack0, m_ack1, m_rv0, m_rv1;

  task automatic model_reset();
    free_at    = 0;
    rv_due     = -1;
    rv_who     = 0;
    m_last     = 1;
    lo[0]      = '0; lo[1] = '0;
    up[0]      = '1; up[1] = '1;
    exp_rdata  = '0;
    exp_rerr   = 1'b0;
    exp_maddr  = '0;
    exp_mextra = '0;
    exp_mlo    = '0;
    exp_mup    = '1;
    m_ack0 = 1'b0; m_ack1 = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
  endtask

  // Called at a negedge: drive inputs, pass one rising edge, check at the next negedge.
  task automatic step(input logic r0, input logic r1,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [MEM_EXTRA-1:0] x0, input logic [MEM_EXTRA-1:0] x1,
                      input logic we, input logic [1:0] sel, input logic [AW-1:0] d);
    int who;
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1; extra0 = x0; extra1 = x1;
    cfg_we = we; cfg_sel = sel; cfg_data = d;
    @(negedge clk);
    m_ack0 = 1'b0; m_ack1 = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
    if (cyc == rv_due) begin
      if (rv_who == 0) m_rv0 = 1'b1; else m_rv1 = 1'b1;
      exp_rdata = pend_data;
      exp_rerr  = pend_err;
      rv_due    = -1;
    end
    if (cyc >= free_at && (r0 || r1)) begin
      who        = (r0 && r1) ? (m_last == 1 ? 0 : 1) : (r1 ? 1 : 0);
      m_last     = who;
      free_at    = cyc + 3;
      rv_due     = cyc + 2;
      rv_who     = who;
      if (who == 0) m_ack0 = 1'b1; else m_ack1 = 1'b1;
      exp_maddr  = (who == 1) ? a1 : a0;
      exp_mextra = (who == 1) ? x1 : x0;
      exp_mlo    = lo[who];
      exp_mup    = up[who];
      pend_data  = rom_word(exp_maddr, exp_mextra);
      pend_err   = rom_err(exp_maddr, lo[who], up[who]);
    end
    if (we) begin
      case (sel)
        2'd0: lo[0] = d;
        2'd1: up[0] = d;
        2'd2: lo[1] = d;
        default: up[1] = d;
      endcase
    end
    check($sformatf("ack0@%0d", cyc), DW'(ack0), DW'(m_ack0));
    check($sformatf("ack1@%0d", cyc), DW'(ack1), DW'(m_ack1));
    check($sformatf("rvalid0@%0d", cyc), DW'(rvalid0), DW'(m_rv0));
    check($sformatf("rvalid1@%0d", cyc), DW'(rvalid1), DW'(m_rv1));
    check($sformatf("busy@%0d", cyc), DW'(busy), DW'(cyc < free_at - 1));
    check($sformatf("rdata@%0d", cyc), rdata, exp_rdata);
    check($sformatf("rerror@%0d", cyc), DW'(rerror), DW'(exp_rerr));
    check($sformatf("mem_addr@%0d", cyc), DW'(mem_addr), DW'(exp_maddr));
    check($sformatf("mem_extra@%0d", cyc), DW'(mem_extra), DW'(exp_mextra));
    check($sformatf("mem_lower@%0d", cyc), DW'(mem_lower), DW'(exp_mlo));
    check($sformatf("mem_upper@%0d", cyc), DW'(mem_upper), DW'(exp_mup));
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, '0, 0, 2'd0, '0);
  endtask

  task automatic reset_mid();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; cfg_we = 1'b0;
    #1;
    check("rst_ack",    DW'({ack0, ack1}), '0);
    check("rst_rvalid", DW'({rvalid0, rvalid1}), '0);
    check("rst_busy",   DW'(busy), '0);
    check("rst_rerror", DW'(rerror), '0);
    check("rst_rdata",  rdata, '0);
    check("rst_maddr",  DW'(mem_addr), '0);
    check("rst_mextra", DW'(mem_extra), '0);
    check("rst_mlower", DW'(mem_lower), '0);
    check("rst_mupper", DW'(mem_upper), DW'({AW{1'b1}}));
    @(negedge clk);
    check("rst_hold_rvalid", DW'({rvalid0, rvalid1}), '0);
    reset = 1'b1;
    cyc++;
    model_reset();
  endtask

  initial begin
    int acks_seen [$];
    int n_ack, n_rv, n_idle;
    logic r0, r1;
    logic [AW-1:0] ra0, ra1;
    logic [MEM_EXTRA-1:0] rx0, rx1;

    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    extra0 = '0; extra1 = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    model_reset();
    cyc = 0;
    repeat (2) @(negedge clk);
    check("por_busy",  DW'(busy), '0);
    check("por_mupper", DW'(mem_upper), DW'({AW{1'b1}}));
    reset = 1'b1;

    // Simultaneous requests straight after reset: requester 0 wins first, then alternate.
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 7'd10, 7'd20, 4'd1, 4'd2, 0, 2'd0, '0);
      if (ack0) acks_seen.push_back(0);
      if (ack1) acks_seen.push_back(1);
    end
    idle(3);
    check("dual_ack_count", DW'(acks_seen.size()), DW'(4));
    for (int i = 0; i < acks_seen.size() && i < 4; i++)
      check($sformatf("dual_order%0d", i), DW'(acks_seen[i]), DW'(i % 2));

    // Single read of address 5.
    step(1, 0, 7'd5, '0, 4'd0, '0, 0, 2'd0, '0);
    idle(2);
    check("single_rdata_byte0", DW'(rdata[7:0]), DW'(8'h05));
    check("single_rerror", DW'(rerror), '0);

    // Bounds enforcement on requester 1 only.
    step(0, 0, '0, '0, '0, '0, 1, 2'd2, 7'd8);
    step(0, 0, '0, '0, '0, '0, 1, 2'd3, 7'd15);
    step(0, 1, '0, 7'd4, '0, 4'd0, 0, 2'd0, '0);
    idle(2);
    check("bounds_r1_err", DW'(rerror), DW'(1));
    step(1, 0, 7'd4, '0, 4'd0, '0, 0, 2'd0, '0);
    idle(2);
    check("bounds_r0_ok", DW'(rerror), '0);

    // Config write during WAIT must not disturb the in-flight bounds.
    step(0, 0, '0, '0, '0, '0, 1, 2'd3, 7'd63);
    step(0, 1, '0, 7'd10, '0, 4'd3, 0, 2'd0, '0);
    idle(1);
    step(0, 0, '0, '0, '0, '0, 1, 2'd3, 7'd2);
    check("flight_upper_kept", DW'(mem_upper), DW'(63));
    step(0, 1, '0, 7'd1, '0, 4'd0, 0, 2'd0, '0);
    check("flight_upper_new", DW'(mem_upper), DW'(2));
    idle(2);

    // Reset while the access is in ISSUE, then a clean read.
    step(1, 0, 7'd7, '0, 4'd2, '0, 0, 2'd0, '0);
    reset_mid();
    step(1, 0, 7'd9, '0, 4'd1, '0, 0, 2'd0, '0);
    check("post_rst_ack0", DW'(ack0), DW'(1));
    idle(2);
    check("post_rst_rvalid0", DW'(rvalid0), DW'(1));

    // Request held for 9 cycles.
    n_ack = 0; n_rv = 0; n_idle = 0;
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 7'd30, '0, 4'd5, '0, 0, 2'd0, '0);
      n_ack  += int'(ack0);
      n_rv   += int'(rvalid0);
      n_idle += int'(!busy);
    end
    check("held_acks", DW'(n_ack), DW'(3));
    check("held_rvalids", DW'(n_rv), DW'(3));
    check("held_busy_low", DW'(n_idle), DW'(3));
    idle(1);

    // Random traffic: requesters hold req until acked; occasional bound writes.
    r0 = 1'b0; r1 = 1'b0; ra0 = '0; ra1 = '0; rx0 = '0; rx1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!r0 && $urandom_range(0, 2) == 0) begin
        r0 = 1'b1; ra0 = AW'($urandom); rx0 = MEM_EXTRA'($urandom);
      end
      if (!r1 && $urandom_range(0, 2) == 0) begin
        r1 = 1'b1; ra1 = AW'($urandom); rx1 = MEM_EXTRA'($urandom);
      end
      step(r0, r1, ra0, ra1, rx0, rx1, ($urandom_range(0, 7) == 0),
           2'($urandom), AW'($urandom));
      if (m_ack0) r0 = 1'b0;
      if (m_ack1) r1 = 1'b0;
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and sequencer for the shared `genrom` instruction/data ROM port. It lets the CPU fetch path (requester 0) and a secondary agent (requester 1, e.g. loader or debug reader) share one ROM. Each requester gets a programmable lower/upper address window that is applied to the ROM bound inputs per access. Accesses are serialized with round-robin fairness, and each read is returned in a registered response slot tagged by requester.

## Interface

- `MEM_ADDR`, default 6: ROM address width parameter. Address buses are `MEM_ADDR+1` bits.
- `MEM_EXTRA`, default 4: width of the extra-length field. The data bus is `2**MEM_EXTRA*8` bits (DW).
- `clk`, input, 1: single clock for the block.
- `reset`, input, 1: asynchronous, active-low reset.
- `req0` / `req1`, input, 1: access request. Level-held until the matching ack.
- `addr0` / `addr1`, input, MEM_ADDR+1: read address. Must be stable while req is high.
- `extra0` / `extra1`, input, MEM_EXTRA: read extra field. Must be stable while req is high.
- `ack0` / `ack1`, output, 1: one-cycle pulse. The request, address and extra field are captured on this cycle.
- `rvalid0` / `rvalid1`, output, 1: one-cycle pulse. `rdata`/`rerror` belong to this requester.
- `rdata`, output, DW: captured ROM data.
- `rerror`, output, 1: captured ROM bounds error.
- `busy`, output, 1: high while an access is in flight (states ISSUE or WAIT).
- `cfg_we`, input, 1: bound-register write strobe.
- `cfg_sel`, input, 2: selects the bound register. 0 = lower0, 1 = upper0, 2 = lower1, 3 = upper1.
- `cfg_data`, input, MEM_ADDR+1: value written to the selected bound register.
- `mem_addr`, output, MEM_ADDR+1: ROM address.
- `mem_extra`, output, MEM_EXTRA: ROM extra field.
- `mem_lower` / `mem_upper`, output, MEM_ADDR+1: ROM bounds for the current access.
- `mem_data`, input, DW: ROM read data.
- `mem_error`, input, 1: ROM bounds error.

## Operation

- **FSM states**
  - IDLE → ISSUE when any req is high (sampled in IDLE only).
  - ISSUE → WAIT unconditionally.
  - WAIT → IDLE unconditionally.
- **Grant on leaving IDLE**
  - With a single requester, that requester is granted.
  - With both requesting, the requester not granted last wins.
  - The `last` pointer resets to 1, so requester 0 wins the first tie.
  - `last` updates on every grant.
- **Registered with the grant:** `mem_addr`, `mem_extra`, and `mem_lower`/`mem_upper` (copied from the granted requester's bound registers). `ackN` pulses for that one cycle.
- **ROM read latency:** the ROM is a synchronous read with 1-cycle latency. It samples the address during ISSUE, and its data is valid during WAIT.
- **Leaving WAIT:** `rdata` ← `mem_data`, `rerror` ← `mem_error`, and `rvalidN` pulses for the granted requester. `rdata`/`rerror` hold until the next capture.
- **Bound registers**
  - Reset values: lower0 = lower1 = 0; upper0 = upper1 = all ones.
  - `cfg_we` writes take effect on the next edge in any state.
  - An in-flight access keeps the bounds latched at grant. A config write never alters `mem_lower`/`mem_upper` mid-access.
- **Config write coinciding with a grant of the same requester:** the grant uses the old value; the new value applies from the next grant.
- **`mem_*` outputs** hold their last values in IDLE.
- **A requester dropping req before its ack** is a protocol violation; the block simply does not grant it.
- **Requester 1 starvation** is impossible: under continuous dual requests, grants alternate 0, 1, 0, 1, …
- **No error-to-trap translation here.** `rerror` is forwarded raw; the CPU decides the trap.

## Timing

- **Reset values:** state IDLE; ack0/1, rvalid0/1, busy, rerror = 0; rdata = 0; mem_addr = 0; mem_extra = 0; mem_lower = 0; mem_upper = all ones; last = 1.
- **Latency:** req sampled high at edge E0 (IDLE) → ack high E0–E1 → rvalid high E2–E3 with data. That is 2 cycles from ack to rvalid.
- **Throughput:** one access per 3 cycles. A req held through rvalid is re-sampled at E3 and granted again if it is still high and wins arbitration.
- **`busy`** is high from E0 to E2.
- **Reset asserted mid-access:** all state and outputs return to reset values immediately (asynchronously). No rvalid is issued for the dropped access, and the bound registers return to their defaults.
- **Reset deasserted:** the first grant is possible at the first rising edge after deassertion.

## Test plan

- **Single read:** ROM preloaded with byte i = i, default bounds. req0 with addr0 = 5, extra0 = 0 → ack0 at E0, rvalid0 at E2, rdata[7:0] = 8'h05, rerror = 0, rvalid1 never asserted.
- **Simultaneous requests after reset:** req0 and req1 held high → ack order 0, 1, 0, 1 at 3-cycle spacing, and each rvalid matches the requester's address.
- **Bounds enforcement:** write lower1 = 8, upper1 = 15. req1 with addr1 = 4 → rvalid1 with rerror = 1. req0 with addr0 = 4 → rerror = 0.
- **Config during flight:** grant req1 with upper1 = 63, then during WAIT write upper1 = 2 → mem_upper stays 63 for that access and is 2 on the next req1 grant.
- **Reset mid-access:** assert reset during ISSUE → all outputs at reset values, no rvalid. After release, a new req0 completes normally at the 2-cycle ack-to-rvalid latency.
- **Held request:** req0 held for 9 cycles → exactly 3 ack0 and 3 rvalid0 pulses, with busy low only one cycle per access.
